// File: rtl/systolic_edge_feeder.sv
// Edge feeder for the systolic tile grid: splits each 8-bit lane operand into two
// nibbles (high first, ctrl-marked) and skews lane k by k*SKEW cycles.
module systolic_edge_feeder #(
    parameter int LANES = 2,
    parameter int SKEW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [LANES*8-1:0]   s_data,
    output logic [LANES*4-1:0]   lane_data,
    output logic [LANES-1:0]     lane_ctrl,
    output logic                 busy,
    output logic [7:0]           word_count
);

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [LANES*8-1:0]   hold;
    logic                 accept;
    logic [LANES*4-1:0]   e_nib;
    logic [LANES-1:0]     e_ctrl;
    logic [LANES-1:0]     e_v;
    logic [LANES-1:0]     stage_busy;

    assign s_ready = ena & ~rst & ((state == IDLE) | (state == LO));
    assign accept  = s_valid & s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? HI : IDLE;
            HI:      state_nxt = LO;
            LO:      state_nxt = accept ? HI : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold       <= '0;
            word_count <= 8'd0;
        end else if (accept) begin
            hold       <= s_data;
            word_count <= word_count + 8'd1;
        end
    end

    // Emission stage: nibble/ctrl/valid per lane, straight from state and hold
    always_comb begin
        e_nib  = '0;
        e_ctrl = '0;
        e_v    = '0;
        for (int k = 0; k < LANES; k++) begin
            if (state == HI) begin
                e_nib[4*k +: 4] = hold[8*k+4 +: 4];
                e_ctrl[k]       = 1'b1;
                e_v[k]          = 1'b1;
            end else if (state == LO) begin
                e_nib[4*k +: 4] = hold[8*k +: 4];
                e_v[k]          = 1'b1;
            end
        end
    end

    assign lane_data[3:0] = e_nib[3:0];
    assign lane_ctrl[0]   = e_ctrl[0];
    assign stage_busy[0]  = 1'b0;

    // Skew stage: lane k passes {nibble, ctrl, v} through k*SKEW registers
    for (genvar k = 1; k < LANES; k++) begin : g_skew
        localparam int DEPTH = k * SKEW;
        logic [5:0] stg [DEPTH];
        logic       any_v;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
            end else if (ena) begin
                stg[0] <= {e_nib[4*k +: 4], e_ctrl[k], e_v[k]};
                for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
            end
        end

        always_comb begin
            any_v = 1'b0;
            for (int i = 0; i < DEPTH; i++) any_v = any_v | stg[i][0];
        end

        assign lane_data[4*k +: 4] = stg[DEPTH-1][5:2];
        assign lane_ctrl[k]        = stg[DEPTH-1][1];
        assign stage_busy[k]       = any_v;
    end

    assign busy = (state != IDLE) | (|stage_busy);

endmodule
